// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int NB_LAT_CNT = 3;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times the WAIT phase of a memory access.
// o_zero flags that the count reaches zero on this cycle's update.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [NB_LAT_CNT-1:0] LOAD_VAL = NB_LAT_CNT'(MEM_LAT - 1);
  localparam logic [NB_LAT_CNT-1:0] CNT_ONE  = NB_LAT_CNT'(1);

  logic [NB_LAT_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_d == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Optional fairness: define MEM_PORT_ARBITER_RR_FAIR_EN for alternating tie-breaks.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32,
  parameter int NB_STRB = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_if_req,
  input  logic [NB_ADDR-1:0] i_if_addr,
  output logic               o_if_gnt,
  output logic               o_if_rvalid,
  output logic [NB_DATA-1:0] o_if_rdata,
  input  logic               i_dm_req,
  input  logic               i_dm_we,
  input  logic [NB_ADDR-1:0] i_dm_addr,
  input  logic [NB_DATA-1:0] i_dm_wdata,
  input  logic [NB_STRB-1:0] i_dm_wstrb,
  output logic               o_dm_gnt,
  output logic               o_dm_rvalid,
  output logic [NB_DATA-1:0] o_dm_rdata,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic [NB_STRB-1:0] o_mem_wstrb,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic               o_sel,
  output logic               o_busy
);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] wdata_q, wdata_d;
  logic [NB_STRB-1:0] wstrb_q, wstrb_d;

  logic any_req, arb_en, win_dm, cnt_zero;
  logic in_issue, in_resp;

  assign any_req = i_if_req | i_dm_req;
  assign arb_en  = ((state_q == IDLE) || (state_q == RESP)) && any_req;

`ifdef MEM_PORT_ARBITER_RR_FAIR_EN
  // On a tie, the side that did not own the previous access wins.
  owner_e last_own_q, last_own_d;

  always_comb begin
    last_own_d = last_own_q;
    if (arb_en) begin
      last_own_d = win_dm ? OWN_DM : OWN_IF;
    end
    if (i_dm_req && i_if_req) begin
      win_dm = (last_own_q == OWN_IF);
    end else begin
      win_dm = i_dm_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      last_own_q <= OWN_IF;
    end else begin
      last_own_q <= last_own_d;
    end
  end
`else
  assign win_dm = i_dm_req;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (cnt_zero) state_d = RESP;
      RESP:    state_d = any_req ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    // Instruction fetches are always reads, so no write data or strobes leak out.
    if (arb_en) begin
      owner_d = win_dm ? OWN_DM : OWN_IF;
      we_d    = win_dm & i_dm_we;
      addr_d  = win_dm ? i_dm_addr : i_if_addr;
      wdata_d = win_dm ? i_dm_wdata : '0;
      wstrb_d = (win_dm && i_dm_we) ? i_dm_wstrb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (in_issue),
    .i_dec   (state_q == WAIT),
    .o_zero  (cnt_zero)
  );

  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign o_mem_en    = in_issue;
  assign o_mem_we    = in_issue & we_q;
  assign o_mem_addr  = in_issue ? addr_q  : '0;
  assign o_mem_wdata = in_issue ? wdata_q : '0;
  assign o_mem_wstrb = in_issue ? wstrb_q : '0;

  assign o_if_gnt = in_issue && (owner_q == OWN_IF);
  assign o_dm_gnt = in_issue && (owner_q == OWN_DM);

  // The mux stays on the owner until its response has been taken.
  assign o_sel  = (state_q != IDLE) && (owner_q == OWN_DM);
  assign o_busy = (state_q != IDLE);

  assign o_if_rvalid = in_resp && (owner_q == OWN_IF);
  assign o_dm_rvalid = in_resp && (owner_q == OWN_DM);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_dm_rdata  = (o_dm_rvalid && !we_q) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; four instances run MEM_LAT = 1..4
// side by side on shared stimulus, each test checks the instance it targets.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] mem_rdata;

  logic        if_gnt    [4];
  logic        if_rvalid [4];
  logic [31:0] if_rdata  [4];
  logic        dm_gnt    [4];
  logic        dm_rvalid [4];
  logic [31:0] dm_rdata  [4];
  logic        mem_en    [4];
  logic        mem_we    [4];
  logic [31:0] mem_addr  [4];
  logic [31:0] mem_wdata [4];
  logic [3:0]  mem_wstrb [4];
  logic        sel       [4];
  logic        busy      [4];

  int n_compared;
  int n_mismatched;
  int cnt_a;
  int cnt_b;
  int n_grants;
  logic [1:0] grant_seq [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_port_arbiter #(
      .NB_ADDR (32),
      .NB_DATA (32),
      .NB_STRB (4),
      .MEM_LAT (g + 1)
    ) u_dut (
      .clk         (clk),
      .i_rst_n     (rst_n),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_gnt    (if_gnt[g]),
      .o_if_rvalid (if_rvalid[g]),
      .o_if_rdata  (if_rdata[g]),
      .i_dm_req    (dm_req),
      .i_dm_we     (dm_we),
      .i_dm_addr   (dm_addr),
      .i_dm_wdata  (dm_wdata),
      .i_dm_wstrb  (dm_wstrb),
      .o_dm_gnt    (dm_gnt[g]),
      .o_dm_rvalid (dm_rvalid[g]),
      .o_dm_rdata  (dm_rdata[g]),
      .o_mem_en    (mem_en[g]),
      .o_mem_we    (mem_we[g]),
      .o_mem_addr  (mem_addr[g]),
      .o_mem_wdata (mem_wdata[g]),
      .o_mem_wstrb (mem_wstrb[g]),
      .i_mem_rdata (mem_rdata),
      .o_sel       (sel[g]),
      .o_busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dmr,
                               input logic dmw, input logic [31:0] dma,
                               input logic [31:0] dmd, input logic [3:0] dms);
    if_req   = ifr;
    if_addr  = ifa;
    dm_req   = dmr;
    dm_we    = dmw;
    dm_addr  = dma;
    dm_wdata = dmd;
    dm_wstrb = dms;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    mem_rdata    = 32'h0;

    // Reset state, with non-zero memory data to prove rdata is gated
    applyReset();
    mem_rdata = 32'h1111_2222;
    #1;
    checkOutput("rst_busy",    32'(busy[0]),      32'h0);
    checkOutput("rst_sel",     32'(sel[0]),       32'h0);
    checkOutput("rst_mem_en",  32'(mem_en[0]),    32'h0);
    checkOutput("rst_if_rdat", if_rdata[0],       32'h0);
    checkOutput("rst_dm_rdat", dm_rdata[0],       32'h0);
    checkOutput("rst_rvalid",  32'(if_rvalid[0]), 32'h0);

    // MEM_LAT=1 instruction fetch
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_rdata = 32'hDEAD_BEEF;
    stepCycle();
    checkOutput("t1_if_gnt",   32'(if_gnt[0]),    32'h1);
    checkOutput("t1_mem_en",   32'(mem_en[0]),    32'h1);
    checkOutput("t1_sel",      32'(sel[0]),       32'h0);
    checkOutput("t1_mem_addr", mem_addr[0],       32'h0000_0010);
    checkOutput("t1_mem_we",   32'(mem_we[0]),    32'h0);
    if_req = 1'b0;
    stepCycle();
    checkOutput("t1_rvalid",   32'(if_rvalid[0]), 32'h1);
    checkOutput("t1_rdata",    if_rdata[0],       32'hDEAD_BEEF);
    checkOutput("t1_dm_rval",  32'(dm_rvalid[0]), 32'h0);
    stepCycle();
    checkOutput("t1_busy",     32'(busy[0]),      32'h0);

    // MEM_LAT=3 simultaneous requests: DM write first, IF after RESP
    applyReset();
    applyStimulus(1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
    mem_rdata = 32'h9999_9999;
    stepCycle();
    checkOutput("t2_dm_gnt",   32'(dm_gnt[2]),    32'h1);
    checkOutput("t2_if_gnt",   32'(if_gnt[2]),    32'h0);
    checkOutput("t2_mem_we",   32'(mem_we[2]),    32'h1);
    checkOutput("t2_sel",      32'(sel[2]),       32'h1);
    checkOutput("t2_mem_addr", mem_addr[2],       32'h0000_0100);
    checkOutput("t2_mem_wdat", mem_wdata[2],      32'h1234_5678);
    checkOutput("t2_mem_strb", 32'(mem_wstrb[2]), 32'hF);
    dm_req = 1'b0;
    stepCycle();
    checkOutput("t2_wait1_rv", 32'(dm_rvalid[2]), 32'h0);
    checkOutput("t2_wait1_sl", 32'(sel[2]),       32'h1);
    stepCycle();
    checkOutput("t2_wait2_rv", 32'(dm_rvalid[2]), 32'h0);
    stepCycle();
    checkOutput("t2_dm_rval",  32'(dm_rvalid[2]), 32'h1);
    checkOutput("t2_dm_rdata", dm_rdata[2],       32'h0);
    stepCycle();
    checkOutput("t2_if_gnt2",  32'(if_gnt[2]),    32'h1);
    checkOutput("t2_if_addr",  mem_addr[2],       32'h0000_0020);
    checkOutput("t2_if_sel",   32'(sel[2]),       32'h0);
    checkOutput("t2_if_we",    32'(mem_we[2]),    32'h0);

    // Continuous DM plus IF on MEM_LAT=1: starvation or alternation
    applyReset();
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    cnt_a    = 0;
    cnt_b    = 0;
    n_grants = 0;
    for (int i = 0; i < 4; i++) grant_seq[i] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      if (if_gnt[0]) cnt_a++;
      if (dm_gnt[0]) cnt_b++;
      if ((if_gnt[0] || dm_gnt[0]) && n_grants < 4) begin
        grant_seq[n_grants] = {1'b0, dm_gnt[0]};
        n_grants++;
      end
    end
`ifdef MEM_PORT_ARBITER_RR_FAIR_EN
    checkOutput("t3_if_count", 32'(cnt_a), 32'd5);
    checkOutput("t3_dm_count", 32'(cnt_b), 32'd5);
    checkOutput("t3_order0",   32'(grant_seq[0]), 32'h1);
    checkOutput("t3_order1",   32'(grant_seq[1]), 32'h0);
    checkOutput("t3_order2",   32'(grant_seq[2]), 32'h1);
    checkOutput("t3_order3",   32'(grant_seq[3]), 32'h0);
`else
    checkOutput("t3_if_count", 32'(cnt_a), 32'd0);
    checkOutput("t3_dm_count", 32'(cnt_b), 32'd10);
    checkOutput("t3_order0",   32'(grant_seq[0]), 32'h1);
    checkOutput("t3_order3",   32'(grant_seq[3]), 32'h1);
`endif

    // MEM_LAT=4 reset during WAIT drops the access
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    mem_rdata = 32'hFFFF_0000;
    stepCycle();
    checkOutput("t4_dm_gnt",   32'(dm_gnt[3]),    32'h1);
    dm_req = 1'b0;
    stepCycle();
    checkOutput("t4_wait_bsy", 32'(busy[3]),      32'h1);
    checkOutput("t4_wait_sel", 32'(sel[3]),       32'h1);
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    checkOutput("t4_rst_busy", 32'(busy[3]),      32'h0);
    checkOutput("t4_rst_sel",  32'(sel[3]),       32'h0);
    checkOutput("t4_rst_en",   32'(mem_en[3]),    32'h0);
    checkOutput("t4_rst_rval", 32'(dm_rvalid[3]), 32'h0);
    checkOutput("t4_rst_rdat", dm_rdata[3],       32'h0);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      if (dm_rvalid[3] || if_rvalid[3]) cnt_a++;
    end
    checkOutput("t4_no_rval",  32'(cnt_a), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    mem_rdata = 32'hCAFE_F00D;
    stepCycle();
    checkOutput("t4_new_gnt",  32'(dm_gnt[3]),    32'h1);
    checkOutput("t4_new_addr", mem_addr[3],       32'h0000_0044);
    dm_req = 1'b0;
    for (int k = 0; k < 3; k++) stepCycle();
    checkOutput("t4_pre_rval", 32'(dm_rvalid[3]), 32'h0);
    stepCycle();
    checkOutput("t4_new_rval", 32'(dm_rvalid[3]), 32'h1);
    checkOutput("t4_new_rdat", dm_rdata[3],       32'hCAFE_F00D);

    // MEM_LAT=2 held IF request: one grant every three cycles
    applyReset();
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      checkOutput($sformatf("t5_gnt_c%0d", k), 32'(if_gnt[1]), 32'((k % 3) == 1));
      if (k == 1) checkOutput("t5_addr_c1", mem_addr[1], 32'h0000_0200);
      if (k == 2) if_addr = 32'h0000_0204;
      if (k == 4) checkOutput("t5_addr_c4", mem_addr[1], 32'h0000_0204);
    end

    // MEM_LAT=2 sub-word DM write
    applyReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0011);
    mem_rdata = 32'h5555_5555;
    stepCycle();
    checkOutput("t6_strb_iss", 32'(mem_wstrb[1]), 32'h3);
    checkOutput("t6_we_iss",   32'(mem_we[1]),    32'h1);
    dm_req = 1'b0;
    stepCycle();
    checkOutput("t6_strb_wt",  32'(mem_wstrb[1]), 32'h0);
    stepCycle();
    checkOutput("t6_ack",      32'(dm_rvalid[1]), 32'h1);
    checkOutput("t6_ack_rdat", dm_rdata[1],       32'h0);
    checkOutput("t6_strb_rsp", 32'(mem_wstrb[1]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
